// File: rtl/divisor_iter.sv
// Sequential radix-2 restoring divider for the FP divide path.
// Produces floor(a * 2^FRAC_BITS / b) one quotient bit per clock, plus a
// sticky flag (remainder != 0) for rounding and a divide-by-zero flag.
// Valid/ready handshakes on both sides; one operation in flight at a time.
module divisor_iter #(
  parameter int WIDTH     = 24,
  parameter int FRAC_BITS = 24
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     q,
  output logic [FRAC_BITS-1:0] f,
  output logic                 sticky,
  output logic                 div_by_zero
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Dividend shifts out MSB first; zeros fill in behind it, which supplies
  // the FRAC_BITS trailing zero bits for the fractional part.
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  // Partial remainder stays below b after every step, so WIDTH bits suffice;
  // the extra bit only exists in the shifted compare below.
  logic [WIDTH-1:0]     r_q;
  // Quotient bits collected so far; the final bit is appended at load time.
  logic [N-2:0]         qsh_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     q_q;
  logic [FRAC_BITS-1:0] f_q;
  logic                 sticky_q;
  logic                 dbz_q;

  logic                 accept;
  logic                 last_step;
  logic [WIDTH:0]       r_shift;
  logic [WIDTH:0]       diff;
  logic                 ge;
  logic [WIDTH-1:0]     r_step;

  // in_ready is forced low while reset is held, not just after release.
  assign in_ready  = arst && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == CW'(1));

  // One restoring step: shift in the next dividend bit, trial-subtract b.
  // A borrow out of the top bit means the shifted remainder was below b.
  assign r_shift = {r_q, a_q[WIDTH-1]};
  assign diff    = r_shift - {1'b0, b_q};
  assign ge      = ~diff[WIDTH];
  assign r_step  = ge ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];

  assign q           = q_q;
  assign f           = f_q;
  assign sticky      = sticky_q;
  assign div_by_zero = dbz_q;

  // State register.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: divide-by-zero skips the iteration entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (b == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      qsh_q    <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
      f_q      <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            r_q   <= '0;
            qsh_q <= '0;
            cnt_q <= CW'(N);
            if (b == '0) begin
              q_q      <= '0;
              f_q      <= '0;
              sticky_q <= 1'b0;
              dbz_q    <= 1'b1;
            end
          end
        end
        S_CALC: begin
          a_q   <= {a_q[WIDTH-2:0], 1'b0};
          r_q   <= r_step;
          qsh_q <= {qsh_q[N-3:0], ge};
          cnt_q <= cnt_q - CW'(1);
          if (last_step) begin
            {q_q, f_q} <= {qsh_q, ge};
            sticky_q   <= (r_step != '0);
            dbz_q      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_iter.sv
// Self-checking bench for divisor_iter: directed vectors, back-pressure,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_divisor_iter;

  localparam int W  = 24;
  localparam int FB = 24;
  localparam int N  = W + FB;

  logic          clk = 1'b0;
  logic          arst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  q;
  logic [FB-1:0] f;
  logic          sticky;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  divisor_iter #(.WIDTH(W), .FRAC_BITS(FB)) dut (
    .clk        (clk),
    .arst       (arst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .f          (f),
    .sticky     (sticky),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: floor(a * 2^FB / b) and its remainder, plain integer arithmetic.
  function automatic logic [N:0] ref_div(input logic [W-1:0] ai, input logic [W-1:0] bi);
    longint unsigned num, quo, rem;
    num = longint'(ai) << FB;
    quo = num / longint'(bi);
    rem = num % longint'(bi);
    return {(rem != 0), quo[N-1:0]};
  endfunction

  // Issue one operation and collect its result. lat = edges after the accept
  // edge until out_valid is seen (capped at 200).
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input bit keep_rdy,
                       output logic [W-1:0] gq, output logic [FB-1:0] gf,
                       output logic gs, output logic gz, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    a = ai;
    b = bi;
    in_valid = 1'b1;
    out_ready = keep_rdy;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    gq = q;
    gf = f;
    gs = sticky;
    gz = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_held got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if ({q, f, sticky, div_by_zero} !== '0) begin errors++; $display("FAIL rst_results got q=%h f=%h s=%b z=%b exp=0", q, f, sticky, div_by_zero); end
    @(negedge clk);
    arst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_release got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] av [4] = '{24'd6, 24'd1, 24'hFFFFFF, 24'h800000};
    logic [W-1:0] bv [4] = '{24'd3, 24'd3, 24'd1, 24'hFFFFFF};
    logic [W-1:0] eq [4] = '{24'd2, 24'd0, 24'hFFFFFF, 24'd0};
    logic [FB-1:0] ef [4] = '{24'd0, 24'h555555, 24'd0, 24'h800000};
    logic es [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] gq; logic [FB-1:0] gf; logic gs, gz; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(av[i], bv[i], 1'b0, gq, gf, gs, gz, lat);
      checks++; if (lat !== N) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, N); end
      checks++; if ({gq, gf} !== {eq[i], ef[i]}) begin errors++; $display("FAIL vec%0d_quot got=%h_%h exp=%h_%h", i, gq, gf, eq[i], ef[i]); end
      checks++; if ({gs, gz} !== {es[i], 1'b0}) begin errors++; $display("FAIL vec%0d_flags got s=%b z=%b exp s=%b z=0", i, gs, gz, es[i]); end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] gq; logic [FB-1:0] gf; logic gs, gz; int lat;
    do_op(24'd5, 24'd0, 1'b0, gq, gf, gs, gz, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dbz_latency got=%0d exp=0 (valid right after accept edge)", lat); end
    checks++; if ({gq, gf, gs, gz} !== {{(N+1){1'b0}}, 1'b1}) begin errors++; $display("FAIL dbz_result got q=%h f=%h s=%b z=%b exp q=0 f=0 s=0 z=1", gq, gf, gs, gz); end
  endtask

  task automatic test_backpressure();
    logic [N:0] r1, r2;
    int lat;
    r1 = ref_div(24'd100, 24'd7);
    r2 = ref_div(24'd9, 24'd4);
    @(negedge clk);
    a = 24'd100; b = 24'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat !== N) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, N); end
    a = 24'd9; b = 24'd4; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {q, f} !== r1[N-1:0] || sticky !== r1[N] || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b q=%h f=%h s=%b z=%b exp v=1 rdy=0 qf=%h s=%b z=0",
                 i, out_valid, in_ready, q, f, sticky, div_by_zero, r1[N-1:0], r1[N]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    checks++; if ({q, f} !== r1[N-1:0]) begin errors++; $display("FAIL bp_result_kept got=%h exp=%h", {q, f}, r1[N-1:0]); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat !== N) begin errors++; $display("FAIL bp_second_latency got=%0d exp=%0d", lat, N); end
    checks++; if ({sticky, q, f} !== r2) begin errors++; $display("FAIL bp_second_result got=%h exp=%h", {sticky, q, f}, r2); end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [W-1:0] gq; logic [FB-1:0] gf; logic gs, gz; int lat;
    @(negedge clk);
    a = 24'd1000; b = 24'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 arst = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL abort_ctrl got v=%b rdy=%b exp 0 0", out_valid, in_ready); end
    checks++; if ({q, f, sticky, div_by_zero} !== '0) begin errors++; $display("FAIL abort_results got q=%h f=%h s=%b z=%b exp=0", q, f, sticky, div_by_zero); end
    @(negedge clk);
    arst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_late_result got=%b exp=0", out_valid); end
    do_op(24'd7, 24'd2, 1'b0, gq, gf, gs, gz, lat);
    checks++; if (lat !== N) begin errors++; $display("FAIL reissue_latency got=%0d exp=%0d", lat, N); end
    checks++; if ({gq, gf, gs, gz} !== {24'd3, 24'h800000, 1'b0, 1'b0}) begin errors++; $display("FAIL reissue_result got q=%h f=%h s=%b z=%b exp q=3 f=800000 s=0 z=0", gq, gf, gs, gz); end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, gq; logic [FB-1:0] gf; logic gs, gz; int lat;
    logic [N:0] exp_r;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 4))
        0: rb = W'($urandom_range(1, 15));
        1: rb = W'($urandom);
        2: rb = ra | W'(1);
        3: rb = W'($urandom) >> $urandom_range(0, 23);
        default: rb = '0;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), gq, gf, gs, gz, lat);
      if (rb == '0) begin
        checks++;
        if (lat !== 0 || {gq, gf, gs, gz} !== {{(N+1){1'b0}}, 1'b1}) begin
          errors++;
          $display("FAIL rand%0d_dbz a=%h got lat=%0d q=%h f=%h s=%b z=%b exp lat=0 z=1 rest 0", i, ra, lat, gq, gf, gs, gz);
        end
      end else begin
        exp_r = ref_div(ra, rb);
        checks++;
        if (lat !== N || {gs, gq, gf} !== exp_r || gz !== 1'b0) begin
          errors++;
          $display("FAIL rand%0d a=%h b=%h got lat=%0d s=%b q=%h f=%h z=%b exp lat=%0d s_qf=%h z=0", i, ra, rb, lat, gs, gq, gf, gz, N, exp_r);
        end
      end
    end
  endtask

  initial begin
    arst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_vectors();
    test_div_zero();
    test_backpressure();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
